lbdr_dr_route_unit: RTL and testbench

//  Parametrised LBDR route unit, one per router input port, between the input FIFO and the switch allocator.

---
 rtl/lbdr_pkg.sv | 41 ++++
 rtl/lbdr_route_calc.sv | 86 ++++++++
 rtl/lbdr_dr_route_unit.sv | 143 ++++++++++++++
 tb/tb_lbdr_dr_route_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lbdr_pkg.sv
// Shared flit codes, port/state encodings and index helpers for the LBDR route unit.
package lbdr_pkg;

   localparam logic [2:0] FLIT_HEADER      = 3'b001;
   localparam logic [2:0] FLIT_BODY        = 3'b010;
   localparam logic [2:0] FLIT_TAIL        = 3'b100;
   localparam logic [2:0] FLIT_HEADER_TAIL = 3'b101;

   typedef enum logic [1:0] {
      PORT_N = 2'd0,
      PORT_E = 2'd1,
      PORT_W = 2'd2,
      PORT_S = 2'd3
   } port_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROUTED = 2'd1,
      ST_DROP   = 2'd2
   } state_e;

   // Bit positions inside the {L,S,W,E,N} request/grant vectors.
   localparam int IDX_N = 0;
   localparam int IDX_E = 1;
   localparam int IDX_W = 2;
   localparam int IDX_S = 3;
   localparam int IDX_L = 4;

   function automatic logic is_header(input logic [2:0] id);
      return (id == FLIT_HEADER) || (id == FLIT_HEADER_TAIL);
   endfunction

   function automatic logic [4:0] port_onehot(input port_e p, input logic loc);
      logic [4:0] oh;
      oh = '0;
      if (loc) oh[IDX_L] = 1'b1;
      else     oh[p]     = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/lbdr_route_calc.sv
// Combinational LBDR output-port selection: minimal route with fixed priority,
// falling back to a per-direction deroute code when the minimal set is empty.
module lbdr_route_calc
   import lbdr_pkg::*;
#(
   parameter int X_BITS     = 2,
   parameter int Y_BITS     = 2,
   parameter int DEROUTE_EN = 1
) (
   input  logic [X_BITS+Y_BITS-1:0] cur_addr_i,
   input  logic [X_BITS+Y_BITS-1:0] dst_addr_i,
   input  logic [7:0]               rxy_i,
   input  logic [3:0]               cx_i,
   input  logic [7:0]               dr_i,
   output port_e                    port_o,
   output logic                     is_local_o,
   output logic                     drop_o
);

   logic [X_BITS-1:0] x_cur, x_dst;
   logic [Y_BITS-1:0] y_cur, y_dst;
   logic              n1, e1, w1, s1;
   logic              rne, rnw, ren, res, rwn, rws, rse, rsw;
   logic [3:0]        cand;
   port_e             pri;
   logic [1:0]        alt_raw;
   port_e             alt;

   assign x_cur = cur_addr_i[X_BITS-1:0];
   assign y_cur = cur_addr_i[X_BITS +: Y_BITS];
   assign x_dst = dst_addr_i[X_BITS-1:0];
   assign y_dst = dst_addr_i[X_BITS +: Y_BITS];

   assign n1 = y_dst < y_cur;
   assign s1 = y_cur < y_dst;
   assign e1 = x_cur < x_dst;
   assign w1 = x_dst < x_cur;

   assign {rsw, rse, rws, rwn, res, ren, rnw, rne} = rxy_i;

   assign cand[IDX_N] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rne) | (n1 & w1 & rnw)) & cx_i[IDX_N];
   assign cand[IDX_E] = ((e1 & ~n1 & ~s1) | (e1 & n1 & ren) | (e1 & s1 & res)) & cx_i[IDX_E];
   assign cand[IDX_W] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rwn) | (w1 & s1 & rws)) & cx_i[IDX_W];
   assign cand[IDX_S] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rse) | (s1 & w1 & rsw)) & cx_i[IDX_S];

   always_comb begin
      pri = PORT_S;
      if      (n1) pri = PORT_N;
      else if (e1) pri = PORT_E;
      else if (w1) pri = PORT_W;
   end

   always_comb begin
      case (pri)
         PORT_N:  alt_raw = dr_i[1:0];
         PORT_E:  alt_raw = dr_i[3:2];
         PORT_W:  alt_raw = dr_i[5:4];
         default: alt_raw = dr_i[7:6];
      endcase
   end

   assign alt = port_e'(alt_raw);

   always_comb begin
      port_o     = PORT_N;
      is_local_o = 1'b0;
      drop_o     = 1'b0;
      if (!(n1 | e1 | w1 | s1)) begin
         is_local_o = 1'b1;
      end else if (cand[IDX_N]) begin
         port_o = PORT_N;
      end else if (cand[IDX_E]) begin
         port_o = PORT_E;
      end else if (cand[IDX_W]) begin
         port_o = PORT_W;
      end else if (cand[IDX_S]) begin
         port_o = PORT_S;
      end else if ((DEROUTE_EN != 0) && cx_i[alt] && (alt != pri)) begin
         // Deroute only onto a connected port that differs from the blocked one.
         port_o = alt;
      end else begin
         drop_o = 1'b1;
      end
   end

endmodule

// File: rtl/lbdr_dr_route_unit.sv
// Per-input-port LBDR route unit: routes a packet on its header, holds a one-hot
// request until the tail is popped on grant, and drains unroutable packets.
//
//   state     | meaning
//   ST_IDLE   | waiting for a header at the FIFO head; non-headers are popped as errors
//   ST_ROUTED | req held; flits popped on matching grant until tail
//   ST_DROP   | unroutable packet being drained until tail
module lbdr_dr_route_unit
   import lbdr_pkg::*;
#(
   parameter int X_BITS     = 2,
   parameter int Y_BITS     = 2,
   parameter int DEROUTE_EN = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               Rxy_rst,
   input  logic [3:0]               Cx_rst,
   input  logic [7:0]               dr_rst,
   input  logic [X_BITS+Y_BITS-1:0] cur_addr_rst,
   input  logic                     empty,
   input  logic [2:0]               flit_id,
   input  logic [X_BITS+Y_BITS-1:0] dst_addr,
   input  logic [4:0]               grant,
   output logic [4:0]               req,
   output logic                     rd_en,
   output logic                     route_err
);

   logic [7:0]               rxy_q;
   logic [3:0]               cx_q;
   logic [7:0]               dr_q;
   logic [X_BITS+Y_BITS-1:0] cur_q;

   state_e     state_q, state_d;
   logic [4:0] req_q, req_d;
   logic       err_q, err_d;
   logic       hdr_popped_q, hdr_popped_d;
   logic       pop;

   port_e      calc_port;
   logic       calc_local;
   logic       calc_drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         rxy_q <= Rxy_rst;
         cx_q  <= Cx_rst;
         dr_q  <= dr_rst;
         cur_q <= cur_addr_rst;
      end
   end

   lbdr_route_calc #(
      .X_BITS     (X_BITS),
      .Y_BITS     (Y_BITS),
      .DEROUTE_EN (DEROUTE_EN)
   ) u_calc (
      .cur_addr_i (cur_q),
      .dst_addr_i (dst_addr),
      .rxy_i      (rxy_q),
      .cx_i       (cx_q),
      .dr_i       (dr_q),
      .port_o     (calc_port),
      .is_local_o (calc_local),
      .drop_o     (calc_drop)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         req_q        <= '0;
         err_q        <= 1'b0;
         hdr_popped_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         err_q        <= err_d;
         hdr_popped_q <= hdr_popped_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      err_d        = 1'b0;
      hdr_popped_d = hdr_popped_q;
      pop          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               if (is_header(flit_id)) begin
                  if (calc_drop) begin
                     pop   = 1'b1;
                     err_d = 1'b1;
                     if (flit_id == FLIT_HEADER) state_d = ST_DROP;
                  end else begin
                     req_d        = port_onehot(calc_port, calc_local);
                     hdr_popped_d = 1'b0;
                     state_d      = ST_ROUTED;
                  end
               end else begin
                  pop   = 1'b1;
                  err_d = 1'b1;
               end
            end
         end
         ST_ROUTED: begin
            if (!empty) begin
               // A header after our own header left means the tail went missing:
               // leave it in the FIFO so IDLE routes it as a fresh packet.
               if (hdr_popped_q && is_header(flit_id)) begin
                  err_d   = 1'b1;
                  req_d   = '0;
                  state_d = ST_IDLE;
               end else if (|(grant & req_q)) begin
                  pop          = 1'b1;
                  hdr_popped_d = 1'b1;
                  if ((flit_id == FLIT_TAIL) || (flit_id == FLIT_HEADER_TAIL)) begin
                     req_d   = '0;
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         ST_DROP: begin
            if (!empty) begin
               pop = 1'b1;
               if (flit_id == FLIT_TAIL) state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = '0;
         end
      endcase
   end

   assign rd_en     = pop & ~rst;
   assign req       = req_q;
   assign route_err = err_q;

endmodule

// File: tb/tb_lbdr_dr_route_unit.sv
// Scoreboard bench for lbdr_dr_route_unit: lane 0 has deroute enabled, lane 1 disabled.
module tb_lbdr_dr_route_unit;
   import lbdr_pkg::*;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] rxy, dr;
   logic [3:0] cx, cur;

   logic       empty [2];
   logic [2:0] fid   [2];
   logic [3:0] dst   [2];
   logic [4:0] grant [2];
   logic [4:0] req   [2];
   logic       rd_en [2];
   logic       err   [2];

   // FIFO entries {flit_id, dst}; expected events {req, rd_en, route_err}.
   logic [6:0] fifo0[$], fifo1[$];
   logic [6:0] exp0[$],  exp1[$];
   logic [7:0] probe_q[$];

   int   errors = 0;
   int   checks = 0;
   logic mon_en = 1'b0;
   logic flush = 1'b0;
   logic final_req = 1'b0;
   logic final_done = 1'b0;

   lbdr_dr_route_unit #(.X_BITS(2), .Y_BITS(2), .DEROUTE_EN(1)) u_dut0 (
      .clk(clk), .rst(rst), .Rxy_rst(rxy), .Cx_rst(cx), .dr_rst(dr), .cur_addr_rst(cur),
      .empty(empty[0]), .flit_id(fid[0]), .dst_addr(dst[0]), .grant(grant[0]),
      .req(req[0]), .rd_en(rd_en[0]), .route_err(err[0]));

   lbdr_dr_route_unit #(.X_BITS(2), .Y_BITS(2), .DEROUTE_EN(0)) u_dut1 (
      .clk(clk), .rst(rst), .Rxy_rst(rxy), .Cx_rst(cx), .dr_rst(dr), .cur_addr_rst(cur),
      .empty(empty[1]), .flit_id(fid[1]), .dst_addr(dst[1]), .grant(grant[1]),
      .req(req[1]), .rd_en(rd_en[1]), .route_err(err[1]));

   // FIFO model: pops on the rd_en seen at the edge, then presents the new head.
   logic pop0, pop1;
   always @(posedge clk) begin
      pop0 = rd_en[0];
      pop1 = rd_en[1];
      #3;
      if (flush) begin
         fifo0.delete();
         fifo1.delete();
      end
      if (pop0 && fifo0.size() != 0) fifo0.delete(0);
      if (pop1 && fifo1.size() != 0) fifo1.delete(0);
      empty[0] = (fifo0.size() == 0);
      empty[1] = (fifo1.size() == 0);
      if (fifo0.size() != 0) {fid[0], dst[0]} = fifo0[0];
      else begin fid[0] = 3'b000; dst[0] = 4'h0; end
      if (fifo1.size() != 0) {fid[1], dst[1]} = fifo1[0];
      else begin fid[1] = 3'b000; dst[1] = 4'h0; end
   end

   // Monitor: any cycle with a pop, an error or a req change is an event.
   logic [7:0] pr;
   logic [6:0] act, want;
   logic       has;
   logic [4:0] prev_req [2];
   int         evn [2];
   initial begin
      prev_req[0] = '0; prev_req[1] = '0;
      evn[0] = 0; evn[1] = 0;
   end

   always @(negedge clk) begin
      while (probe_q.size() != 0) begin
         pr  = probe_q.pop_front();
         act = {req[pr[7]], rd_en[pr[7]], err[pr[7]]};
         checks++;
         if (act !== pr[6:0]) begin
            errors++;
            $display("FAIL probe lane%0d actual={req,rd,err}=%b required=%b", pr[7], act, pr[6:0]);
         end
      end
      if (mon_en) begin
         for (int l = 0; l < 2; l++) begin
            act = {req[l], rd_en[l], err[l]};
            if (rd_en[l] || err[l] || (req[l] != prev_req[l])) begin
               checks++;
               has = (l == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
               if (!has) begin
                  errors++;
                  $display("FAIL lane%0d unexpected_event%0d actual=%b required=none", l, evn[l], act);
               end else begin
                  if (l == 0) want = exp0.pop_front();
                  else        want = exp1.pop_front();
                  if (act !== want) begin
                     errors++;
                     $display("FAIL lane%0d event%0d actual={req,rd,err}=%b required=%b", l, evn[l], act, want);
                  end
               end
               evn[l]++;
            end
            prev_req[l] = req[l];
         end
      end
      if (final_req && !final_done) begin
         checks++;
         if (exp0.size() != 0) begin
            errors++;
            $display("FAIL lane0 pending_events actual=%0d required=0", exp0.size());
         end
         checks++;
         if (exp1.size() != 0) begin
            errors++;
            $display("FAIL lane1 pending_events actual=%0d required=0", exp1.size());
         end
         final_done = 1'b1;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push(input int l, input logic [2:0] f, input logic [3:0] d);
      if (l == 0) fifo0.push_back({f, d});
      else        fifo1.push_back({f, d});
   endtask

   task automatic ex(input int l, input logic [4:0] r, input logic rd, input logic e);
      if (l == 0) exp0.push_back({r, rd, e});
      else        exp1.push_back({r, rd, e});
   endtask

   task automatic probe(input int l, input logic [4:0] r, input logic rd, input logic e);
      logic lb;
      lb = (l != 0);
      probe_q.push_back({lb, r, rd, e});
   endtask

   task automatic rst_cfg(input logic [7:0] r, input logic [3:0] c, input logic [7:0] d,
                          input logic [3:0] a);
      rst = 1'b1; rxy = r; cx = c; dr = d; cur = a;
      grant[0] = '0; grant[1] = '0;
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rxy = 8'd60; cx = 4'hF; dr = 8'h00; cur = 4'd5;
      grant[0] = '0; grant[1] = '0;
      step(3);
      rst = 1'b0;
      probe(0, 5'b00000, 1'b0, 1'b0);
      probe(1, 5'b00000, 1'b0, 1'b0);
      @(negedge clk);
      mon_en = 1'b1;
      step(1);

      // 1: cur=5, dst=7 -> E; three flits popped on grant E.
      ex(0, 5'b00010, 0, 0);
      ex(0, 5'b00010, 1, 0); ex(0, 5'b00010, 1, 0); ex(0, 5'b00010, 1, 0);
      ex(0, 5'b00000, 0, 0);
      push(0, FLIT_HEADER, 4'd7); push(0, FLIT_BODY, 4'd0); push(0, FLIT_TAIL, 4'd0);
      step(2); grant[0] = 5'b00010; step(5); grant[0] = '0; step(2);

      // 2: dst=cur -> local; single-flit packet.
      ex(0, 5'b10000, 0, 0); ex(0, 5'b10000, 1, 0); ex(0, 5'b00000, 0, 0);
      push(0, FLIT_HEADER_TAIL, 4'd5);
      step(2); grant[0] = 5'b10000; step(4); grant[0] = '0; step(2);

      // 3: Ce=0, dr[E]=N, dst=6: lane0 deroutes to N, lane1 drops and drains.
      rst_cfg(8'd60, 4'b1101, 8'h00, 4'd5);
      step(1);
      ex(0, 5'b00001, 0, 0);
      ex(0, 5'b00001, 1, 0); ex(0, 5'b00001, 1, 0); ex(0, 5'b00001, 1, 0);
      ex(0, 5'b00000, 0, 0);
      ex(1, 5'b00000, 1, 0); ex(1, 5'b00000, 1, 1); ex(1, 5'b00000, 1, 0);
      for (int l = 0; l < 2; l++) begin
         push(l, FLIT_HEADER, 4'd6); push(l, FLIT_BODY, 4'd0); push(l, FLIT_TAIL, 4'd0);
      end
      step(2); grant[0] = 5'b00001; step(5); grant[0] = '0; step(2);
      ex(1, 5'b00000, 1, 0); ex(1, 5'b00000, 0, 1);
      push(1, FLIT_HEADER_TAIL, 4'd6);
      step(3);

      // 4: dst=4 -> W; held without grant, wrong-port grant ignored.
      ex(0, 5'b00100, 0, 0);
      push(0, FLIT_HEADER, 4'd4); push(0, FLIT_BODY, 4'd0); push(0, FLIT_TAIL, 4'd0);
      step(10);
      grant[0] = 5'b01000;
      step(2);
      probe(0, 5'b00100, 1'b0, 1'b0);
      step(1);
      ex(0, 5'b00100, 1, 0); ex(0, 5'b00100, 1, 0); ex(0, 5'b00100, 1, 0);
      ex(0, 5'b00000, 0, 0);
      grant[0] = 5'b00100; step(5); grant[0] = '0; step(2);

      // 5a: stray BODY in IDLE.
      ex(0, 5'b00000, 1, 0); ex(0, 5'b00000, 0, 1);
      push(0, FLIT_BODY, 4'd0);
      step(3);

      // 5b: HEADER,BODY,HEADER,TAIL: missing tail, second header re-routed.
      ex(0, 5'b00100, 0, 0); ex(0, 5'b00100, 1, 0); ex(0, 5'b00100, 1, 0);
      ex(0, 5'b00000, 0, 1);
      ex(0, 5'b00100, 1, 0); ex(0, 5'b00100, 1, 0); ex(0, 5'b00000, 0, 0);
      push(0, FLIT_HEADER, 4'd4); push(0, FLIT_BODY, 4'd0);
      push(0, FLIT_HEADER, 4'd4); push(0, FLIT_TAIL, 4'd0);
      step(2); grant[0] = 5'b00100; step(8); grant[0] = '0; step(2);

      // 6: reset after one body flit; new cur=0, Cx=15: dst=5 -> E via Res.
      ex(0, 5'b00100, 0, 0); ex(0, 5'b00100, 1, 0); ex(0, 5'b00100, 1, 0);
      ex(0, 5'b00000, 0, 0);
      push(0, FLIT_HEADER, 4'd4); push(0, FLIT_BODY, 4'd0);
      push(0, FLIT_BODY, 4'd0); push(0, FLIT_TAIL, 4'd0);
      step(2); grant[0] = 5'b00100; step(2);
      rst_cfg(8'd60, 4'hF, 8'h00, 4'd0);
      step(2);
      ex(0, 5'b00010, 0, 0); ex(0, 5'b00010, 1, 0); ex(0, 5'b00010, 1, 0);
      ex(0, 5'b00000, 0, 0);
      push(0, FLIT_HEADER, 4'd5); push(0, FLIT_TAIL, 4'd0);
      step(2); grant[0] = 5'b00010; step(4); grant[0] = '0; step(3);

      final_req = 1'b1;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
